// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - fetch-stage bundle: imem request/response, decode handoff, PC redirect
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [5:0]  if_opcode;
  logic [31:0] if_pc_plus4;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_fault;

  modport master (
    output imem_req, imem_addr,
    input  imem_valid, imem_rdata,
    output if_valid, if_instr, if_opcode, if_pc_plus4, if_fault,
    input  if_ready,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_valid, imem_rdata,
    input  if_valid, if_instr, if_opcode, if_pc_plus4, if_fault,
    output if_ready,
    output redirect_valid, redirect_pc
  );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - MIPS fetch stage: PC, imem request, fetch register, redirects
// Optional misaligned-redirect trap: IFETCH_ALIGN_CHECK_EN
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic           clk,
  input logic           rst_n,
  instr_fetch_if.master bus
);

`ifdef IFETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {IDLE, REQ, HOLD, FAULT} state_t;
`else
  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
`endif

  state_t      state, nextState;
  logic [31:0] pc, pcNext;
  logic [31:0] instrReg, instrNext;
  logic [31:0] pcPlus4Reg, pcPlus4Next;
  logic        drop, dropNext;
  logic        pend, pendNext;
  logic [31:0] pendPc, pendPcNext;
  logic [31:0] pcInc;
  logic [31:0] redirectTarget;

  assign pcInc          = pc + 32'd4;
  assign redirectTarget = {bus.redirect_pc[31:2], 2'b00};

`ifdef IFETCH_ALIGN_CHECK_EN
  logic faultReg, faultNext;
  logic badRedirect;
  assign badRedirect = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
`else
  logic unusedLowBits;
  assign unusedLowBits = ^bus.redirect_pc[1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      instrReg   <= 32'd0;
      pcPlus4Reg <= 32'd0;
      drop       <= 1'b0;
      pend       <= 1'b0;
      pendPc     <= 32'd0;
    end else begin
      state      <= nextState;
      pc         <= pcNext;
      instrReg   <= instrNext;
      pcPlus4Reg <= pcPlus4Next;
      drop       <= dropNext;
      pend       <= pendNext;
      pendPc     <= pendPcNext;
    end
  end

`ifdef IFETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) faultReg <= 1'b0;
    else        faultReg <= faultNext;
  end
`endif

  always_comb begin
    nextState   = state;
    pcNext      = pc;
    instrNext   = instrReg;
    pcPlus4Next = pcPlus4Reg;
    dropNext    = drop;
    pendNext    = pend;
    pendPcNext  = pendPc;
`ifdef IFETCH_ALIGN_CHECK_EN
    faultNext   = faultReg || badRedirect;
`endif

    case (state)
      IDLE: begin
        nextState = REQ;
        if (bus.redirect_valid) pcNext = redirectTarget;
`ifdef IFETCH_ALIGN_CHECK_EN
        if (badRedirect) nextState = FAULT;
`endif
      end

      REQ: begin
        if (bus.imem_valid) begin
          if (bus.redirect_valid) begin
            pcNext   = redirectTarget;
            dropNext = 1'b0;
            pendNext = 1'b0;
          end else if (drop) begin
            pcNext   = pendPc;
            dropNext = 1'b0;
            pendNext = 1'b0;
          end else begin
            instrNext   = bus.imem_rdata;
            pcPlus4Next = pcInc;
            nextState   = HOLD;
          end
        end else if (bus.redirect_valid) begin
          // The request in flight cannot be withdrawn; remember where to go once it returns.
          dropNext   = 1'b1;
          pendNext   = 1'b1;
          pendPcNext = redirectTarget;
        end
`ifdef IFETCH_ALIGN_CHECK_EN
        if ((faultReg || badRedirect) && bus.imem_valid) nextState = FAULT;
`endif
      end

      HOLD: begin
        if (bus.redirect_valid) begin
          pcNext    = redirectTarget;
          nextState = REQ;
        end else if (bus.if_ready) begin
          pcNext    = pcInc;
          nextState = REQ;
        end
`ifdef IFETCH_ALIGN_CHECK_EN
        if (badRedirect) nextState = FAULT;
`endif
      end

`ifdef IFETCH_ALIGN_CHECK_EN
      FAULT: nextState = FAULT;
`endif

      default: nextState = IDLE;
    endcase
  end

  assign bus.imem_req    = (state == REQ);
  assign bus.imem_addr   = pc;
  assign bus.if_valid    = (state == HOLD);
  assign bus.if_instr    = instrReg;
  assign bus.if_opcode   = instrReg[31:26];
  assign bus.if_pc_plus4 = pcPlus4Reg;
`ifdef IFETCH_ALIGN_CHECK_EN
  assign bus.if_fault    = faultReg;
`else
  assign bus.if_fault    = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed bench for instr_fetch with a transaction-level fetch model
module tb_instr_fetch;
  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   xfers = 0;
  int   memWait = 2;
  int   memCnt  = 0;

  instr_fetch_if ifc();

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memData(input logic [31:0] a);
    if (a == 32'd0) return 32'h2008_0005;
    return {6'h23, a[27:2]};
  endfunction

  // Memory: answers each request after memWait idle cycles with a one-cycle strobe.
  always @(posedge clk) begin
    bit was;
    #2;
    was = ifc.imem_valid;
    ifc.imem_valid = 1'b0;
    if (!rst_n) begin
      memCnt = 0;
    end else begin
      if (was) memCnt = 0;
      if (ifc.imem_req) begin
        if (memCnt >= memWait) begin
          ifc.imem_valid = 1'b1;
          ifc.imem_rdata = memData(ifc.imem_addr);
        end else begin
          memCnt++;
        end
      end
    end
  end

  // Model: where the next fetch must go, whether an in-flight response is stale, what is held.
  localparam int PH_IDLE = 0, PH_FETCH = 1, PH_HOLD = 2, PH_FAULT = 3;
  int          mPhase;
  logic [31:0] mAddr, mPend, mInstr, mPc4;
  bit          mStale, mDoomed, mFault;

  always @(negedge clk) begin
    logic [31:0] tgt;
    bit          rv, iv, badRd;
    if (!rst_n) begin
      mPhase = PH_IDLE; mAddr = 32'd0; mPend = 32'd0; mInstr = 32'd0; mPc4 = 32'd0;
      mStale = 0; mDoomed = 0; mFault = 0;
    end else begin
      chk("imem_req", 32'(ifc.imem_req), 32'(mPhase == PH_FETCH));
      if (mPhase == PH_FETCH) chk("imem_addr", ifc.imem_addr, mAddr);
      chk("if_valid", 32'(ifc.if_valid), 32'(mPhase == PH_HOLD));
      chk("if_instr", ifc.if_instr, mInstr);
      chk("if_opcode", 32'(ifc.if_opcode), 32'(mInstr >> 26));
      chk("if_pc_plus4", ifc.if_pc_plus4, mPc4);
      chk("if_fault", 32'(ifc.if_fault), 32'(mFault));
      if (ifc.if_valid && ifc.if_ready) xfers++;

      rv    = ifc.redirect_valid;
      iv    = ifc.imem_valid;
      tgt   = ifc.redirect_pc & 32'hFFFF_FFFC;
      badRd = 0;
`ifdef IFETCH_ALIGN_CHECK_EN
      badRd = rv && ((ifc.redirect_pc & 32'd3) != 32'd0);
`endif
      case (mPhase)
        PH_IDLE: begin
          mPhase = PH_FETCH;
          if (rv) mAddr = tgt;
          if (badRd) begin mFault = 1; mPhase = PH_FAULT; end
        end
        PH_FETCH: begin
          if (badRd) begin mFault = 1; mDoomed = 1; end
          if (iv) begin
            if (mDoomed) mPhase = PH_FAULT;
            else if (rv) begin mAddr = tgt; mStale = 0; end
            else if (mStale) begin mAddr = mPend; mStale = 0; end
            else begin mInstr = ifc.imem_rdata; mPc4 = mAddr + 32'd4; mPhase = PH_HOLD; end
          end else if (rv && !mDoomed) begin
            mStale = 1; mPend = tgt;
          end
        end
        PH_HOLD: begin
          if (badRd) begin mFault = 1; mPhase = PH_FAULT; end
          else if (rv) begin mAddr = tgt; mPhase = PH_FETCH; end
          else if (ifc.if_ready) begin mAddr = mAddr + 32'd4; mPhase = PH_FETCH; end
        end
        default: ;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitHold(input string name);
    int n = 0;
    while (!ifc.if_valid && n < 40) begin tick(); n++; end
    chk(name, 32'(ifc.if_valid), 32'd1);
  endtask

  task automatic waitLeave(input logic [31:0] a);
    int n = 0;
    while (ifc.imem_addr == a && n < 40) begin tick(); n++; end
  endtask

  task automatic redirect(input logic [31:0] target);
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = target;
    tick();
    ifc.redirect_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    rst_n = 1'b0;
    ifc.if_ready = 1'b0;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc = 32'd0;
    ifc.imem_valid = 1'b0;
    ifc.imem_rdata = 32'd0;
    repeat (3) tick();
    chk("reset_req", 32'(ifc.imem_req), 32'd0);
    chk("reset_addr", ifc.imem_addr, 32'd0);
    chk("reset_instr", ifc.if_instr, 32'd0);

    // reset release edge, then one idle cycle; 2 memory wait cycles
    @(posedge clk); #1; rst_n = 1'b1;
    chk("idle_cycle_req", 32'(ifc.imem_req), 32'd0);
    tick();
    chk("first_req", 32'(ifc.imem_req), 32'd1);
    chk("first_addr", ifc.imem_addr, 32'd0);
    tick(); tick();
    chk("valid_before_resp", 32'(ifc.if_valid), 32'd0);
    tick();
    chk("first_valid", 32'(ifc.if_valid), 32'd1);
    chk("first_opcode", 32'(ifc.if_opcode), 32'h08);
    chk("first_pc4", ifc.if_pc_plus4, 32'd4);
    chk("first_instr", ifc.if_instr, 32'h2008_0005);

    // decode stalls five cycles
    repeat (5) begin
      tick();
      chk("stall_instr", ifc.if_instr, 32'h2008_0005);
      chk("stall_req", 32'(ifc.imem_req), 32'd0);
    end
    ifc.if_ready = 1'b1; tick(); ifc.if_ready = 1'b0;
    chk("after_xfer_addr", ifc.imem_addr, 32'd4);

    // redirect while waiting on address 8
    waitHold("hold_addr4");
    ifc.if_ready = 1'b1; tick(); ifc.if_ready = 1'b0;
    chk("req_addr8", ifc.imem_addr, 32'd8);
    redirect(32'h40);
    chk("addr8_held", ifc.imem_addr, 32'd8);
    waitLeave(32'd8);
    chk("discard_no_valid", 32'(ifc.if_valid), 32'd0);
    chk("redirect_addr40", ifc.imem_addr, 32'h40);

    // redirect on the same cycle as a transfer
    waitHold("hold_addr40");
    ifc.if_ready = 1'b1; redirect(32'h100); ifc.if_ready = 1'b0;
    chk("redirect_addr100", ifc.imem_addr, 32'h100);

    // wrap at top of address space
    waitHold("hold_addr100");
    redirect(32'hFFFF_FFFC);
    chk("addr_top", ifc.imem_addr, 32'hFFFF_FFFC);
    waitHold("hold_top");
    chk("top_pc4_wrap", ifc.if_pc_plus4, 32'd0);
    memWait = 0;
    ifc.if_ready = 1'b1; tick(); ifc.if_ready = 1'b0;
    chk("wrap_addr0", ifc.imem_addr, 32'd0);

    // zero-wait streaming: one transfer every two cycles
    ifc.if_ready = 1'b1;
    cnt = 0;
    repeat (8) begin
      tick();
      if (ifc.if_valid && ifc.if_ready) cnt++;
    end
    ifc.if_ready = 1'b0;
    chk("stream_count", 32'(cnt), 32'd4);
    tick();
    chk("stream_hold16_pc4", ifc.if_pc_plus4, 32'd20);

    // two redirects while one request is outstanding: last one wins
    memWait = 4;
    ifc.if_ready = 1'b1; tick(); ifc.if_ready = 1'b0;
    chk("req_addr20", ifc.imem_addr, 32'd20);
    redirect(32'h200);
    tick();
    redirect(32'h300);
    waitLeave(32'd20);
    chk("overwrite_addr300", ifc.imem_addr, 32'h300);

    // redirect coinciding with the response strobe
    repeat (4) tick();
    redirect(32'h500);
    chk("coincide_addr500", ifc.imem_addr, 32'h500);
    chk("coincide_no_valid", 32'(ifc.if_valid), 32'd0);

    // misaligned redirect
    memWait = 0;
    waitHold("hold_addr500");
    redirect(32'h42);
`ifdef IFETCH_ALIGN_CHECK_EN
    chk("fault_set", 32'(ifc.if_fault), 32'd1);
    chk("fault_valid", 32'(ifc.if_valid), 32'd0);
    repeat (4) begin
      tick();
      chk("fault_req_low", 32'(ifc.imem_req), 32'd0);
    end
    rst_n = 1'b0; #1;
    chk("fault_cleared", 32'(ifc.if_fault), 32'd0);
`else
    chk("masked_addr40", ifc.imem_addr, 32'h40);
    chk("masked_req", 32'(ifc.imem_req), 32'd1);
    // asynchronous reset mid-request
    rst_n = 1'b0; #1;
    chk("async_req_drop", 32'(ifc.imem_req), 32'd0);
    chk("async_addr", ifc.imem_addr, 32'd0);
    chk("async_instr", ifc.if_instr, 32'd0);
`endif
    chk("async_valid", 32'(ifc.if_valid), 32'd0);
    chk("xfer_count", 32'(xfers), 32'd9);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
